fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, the PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 8'h02, the PC increment per fetched instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-high.
REQ-005 SHALL have port stall, input, 1, hazard-unit hold request.
REQ-006 SHALL have port redirect, input, 1, taken branch or jump pulse.
REQ-007 SHALL have port redirect_pc, input, 8, the branch or jump target.
REQ-008 SHALL have port halt_req, input, 1, halt decoded.
REQ-009 SHALL have port resume, input, 1, leave HALT.
REQ-010 SHALL have port imem_addr, output, 8, the instruction-memory read address.
REQ-011 SHALL have ports imem_hi and imem_lo, inputs, 8 each, combinational memory bytes at addr and addr+1.
REQ-012 SHALL have port if_instr, output, 24, the IF/ID register {pc, hi, lo}.
REQ-013 SHALL have port if_valid, output, 1, marking if_instr as a real instruction.
REQ-014 SHALL have port pc, output, 8, the current fetch PC.
REQ-015 SHALL have port fetch_state, output, 2, the FSM state encoding.
REQ-016 SHALL have port fetch_count, output, 8, the count of valid fetches.

Function
REQ-017 SHALL implement FSM states BOOT=0, RUN=1, STALL=2, HALT=3.
REQ-018 SHALL drive imem_addr = pc combinationally, with zero-cycle read assumed.
REQ-019 BOOT SHALL last exactly one cycle after reset release, with if_valid=0 and pc unchanged, then go to RUN.
REQ-020 In RUN with no stall, redirect or halt_req, each edge SHALL do: if_instr<={pc,imem_hi,imem_lo}; if_valid<=1; pc<=pc+PC_STEP; fetch_count++.
REQ-021 The next-PC sum SHALL be 8-bit and wrap modulo 256 (8'hFE+2 gives 8'h00, no flag); fetch_count SHALL also wrap.
REQ-022 stall=1 in RUN SHALL move to STALL; in STALL, pc, if_instr, if_valid and fetch_count SHALL hold; stall=0 SHALL return to RUN and fetch resumes that edge.
REQ-023 redirect=1 in any state except BOOT SHALL load pc<=redirect_pc, set if_valid<=0 and if_instr<=24'h0 (one bubble), and go to RUN.
REQ-024 redirect SHALL take priority over stall, halt_req and resume in the same cycle; a stall still asserted is honored on the following edge.
REQ-025 An odd redirect_pc SHALL be accepted unchanged.
REQ-026 halt_req in RUN or STALL without redirect SHALL go to HALT with if_valid<=0 and pc held at the halting PC.
REQ-027 In HALT, only resume or redirect SHALL exit; resume goes to RUN with pc unchanged, and stall is ignored.
REQ-028 Inputs arriving during BOOT SHALL be ignored.
REQ-029 if_valid SHALL never be 1 for an instruction fetched at a PC superseded by a same-cycle redirect.

Reset
REQ-030 reset=1 SHALL immediately, without waiting for clk, set pc=RESET_PC, if_instr=24'h0, if_valid=0, fetch_count=0 and state=BOOT.
REQ-031 Reset mid-operation (including in STALL or HALT) SHALL discard all in-flight state with no residual bubble or count.
REQ-032 While reset is held, all inputs SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold the state enum (BOOT/RUN/STALL/HALT), the instruction width 24, the address width 8 and the default PC_STEP.
REQ-034 One sub-module, pc_next_mux, SHALL be used: a combinational select of pc+PC_STEP, redirect_pc or pc.
REQ-035 Outputs SHALL be registered, except imem_addr, which follows pc.

Verification
REQ-036 Reset, then 3 run cycles with mem[0..5]=00,00,00,00,70,00 -> cycle after BOOT: if_instr 24'h000000; then 24'h020000; then 24'h047000; pc=8'h06; fetch_count=3.
REQ-037 stall high for 2 cycles at pc=8'h04 -> if_instr, pc and fetch_count frozen; on release the next if_instr is {8'h04,...}.
REQ-038 redirect with redirect_pc=8'h20 while stall=1 -> next edge: pc=8'h20, if_valid=0; following edge (stall low): if_instr[23:16]=8'h20, if_valid=1.
REQ-039 pc=8'hFE in RUN -> if_instr[23:16]=8'hFE, then pc=8'h00 with no error.
REQ-040 halt_req at pc=8'h40 -> HALT, if_valid=0 and pc=8'h40 across 5 cycles even with stall toggling; resume -> fetch from 8'h40.
REQ-041 Assert reset asynchronously mid-STALL -> outputs reach reset values before the next clk edge; state=BOOT.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg : shared types and widths for the fetch sequencer
// Revision: 1.0
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int c_ADDR_W  = 8;
  localparam int c_INSTR_W = 24;
  localparam int c_CNT_W   = 8;
  localparam logic [c_ADDR_W-1:0] c_PC_STEP_DEFAULT = 8'h02;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pc_next_mux : combinational next-PC select (hold / increment / redirect)
// Revision: 1.0
// -----------------------------------------------------------------------------
module pc_next_mux
  import fetch_sequencer_pkg::*;
#(
  parameter logic [c_ADDR_W-1:0] PC_STEP = c_PC_STEP_DEFAULT
) (
  input  pc_sel_e               i_sel,
  input  logic [c_ADDR_W-1:0]   i_pc,
  input  logic [c_ADDR_W-1:0]   i_redirect_pc,
  output logic [c_ADDR_W-1:0]   o_next_pc
);

  // 8-bit sum wraps modulo 256 by construction
  logic [c_ADDR_W-1:0] w_pc_inc;
  assign w_pc_inc = i_pc + PC_STEP;

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_INC:   o_next_pc = w_pc_inc;
      PC_REDIR: o_next_pc = i_redirect_pc;
      default:  o_next_pc = i_pc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_sequencer : instruction-fetch FSM driving the IF/ID register
// Revision: 1.0
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [c_ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [c_ADDR_W-1:0] PC_STEP  = c_PC_STEP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [c_ADDR_W-1:0]   redirect_pc,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [c_ADDR_W-1:0]   imem_addr,
  input  logic [7:0]            imem_hi,
  input  logic [7:0]            imem_lo,
  output logic [c_INSTR_W-1:0]  if_instr,
  output logic                  if_valid,
  output logic [c_ADDR_W-1:0]   pc,
  output logic [1:0]            fetch_state,
  output logic [c_CNT_W-1:0]    fetch_count
);

  fetch_state_e           r_state;
  logic [c_ADDR_W-1:0]    r_pc;
  logic [c_INSTR_W-1:0]   r_instr;
  logic                   r_valid;
  logic [c_CNT_W-1:0]     r_count;

  fetch_state_e           w_state_nxt;
  pc_sel_e                w_pc_sel;
  logic [c_ADDR_W-1:0]    w_pc_next;
  logic                   w_fetch;
  logic                   w_bubble;
  logic                   w_drop_valid;

  pc_next_mux #(
    .PC_STEP (PC_STEP)
  ) u_pc_next_mux (
    .i_sel         (w_pc_sel),
    .i_pc          (r_pc),
    .i_redirect_pc (redirect_pc),
    .o_next_pc     (w_pc_next)
  );

  // Redirect outranks every other request once out of BOOT.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_sel     = PC_HOLD;
    w_fetch      = 1'b0;
    w_bubble     = 1'b0;
    w_drop_valid = 1'b0;
    if (r_state == ST_BOOT) begin
      w_state_nxt = ST_RUN;
    end else if (redirect) begin
      w_state_nxt = ST_RUN;
      w_pc_sel    = PC_REDIR;
      w_bubble    = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_STALL: begin
          if (halt_req) begin
            w_state_nxt  = ST_HALT;
            w_drop_valid = 1'b1;
          end else if (stall) begin
            w_state_nxt = ST_STALL;
          end else begin
            w_state_nxt = ST_RUN;
            w_pc_sel    = PC_INC;
            w_fetch     = 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_fetch) begin
        r_instr <= {r_pc, imem_hi, imem_lo};
        r_valid <= 1'b1;
        r_count <= r_count + 1'b1;
      end else if (w_bubble) begin
        r_instr <= '0;
        r_valid <= 1'b0;
      end else if (w_drop_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign if_instr    = r_instr;
  assign if_valid    = r_valid;
  assign fetch_count = r_count;
  assign fetch_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fetch_sequencer : directed self-checking bench for fetch_sequencer
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_hi;
  logic [7:0]  imem_lo;
  logic [23:0] if_instr;
  logic        if_valid;
  logic [7:0]  pc;
  logic [1:0]  fetch_state;
  logic [7:0]  fetch_count;

  logic [7:0]  mem [256];
  logic [7:0]  w_lo_addr;

  int n_checks;
  int n_fail;

  fetch_sequencer #(
    .RESET_PC (8'h00),
    .PC_STEP  (8'h02)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .imem_addr   (imem_addr),
    .imem_hi     (imem_hi),
    .imem_lo     (imem_lo),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .pc          (pc),
    .fetch_state (fetch_state),
    .fetch_count (fetch_count)
  );

  assign w_lo_addr = imem_addr + 8'd1;
  assign imem_hi   = mem[imem_addr];
  assign imem_lo   = mem[w_lo_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    halt_req    = 1'b0;
    resume      = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[4]    = 8'h70;
    mem[8'hFE] = 8'hAB;
    mem[8'hFF] = 8'hCD;

    // reset held with inputs wiggling
    tick();
    redirect = 1'b1; redirect_pc = 8'h33; stall = 1'b1;
    tick();
    chk("rst_pc",    32'(pc), 32'h00);
    chk("rst_instr", 32'(if_instr), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_count", 32'(fetch_count), 32'h0);
    chk("rst_state", 32'(fetch_state), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'h00);

    // BOOT edge ignores inputs
    reset = 1'b0;
    tick();
    chk("boot_state", 32'(fetch_state), 32'd1);
    chk("boot_pc",    32'(pc), 32'h00);
    chk("boot_valid", 32'(if_valid), 32'h0);
    redirect = 1'b0; stall = 1'b0;

    tick();
    chk("run0_instr", 32'(if_instr), 32'h000000);
    chk("run0_valid", 32'(if_valid), 32'h1);
    tick();
    chk("run1_instr", 32'(if_instr), 32'h020000);
    tick();
    chk("run2_instr", 32'(if_instr), 32'h047000);
    chk("run2_pc",    32'(pc), 32'h06);
    chk("run2_count", 32'(fetch_count), 32'd3);

    // stall at pc 04
    redirect = 1'b1; redirect_pc = 8'h04;
    tick();
    chk("rd04_pc",    32'(pc), 32'h04);
    chk("rd04_valid", 32'(if_valid), 32'h0);
    chk("rd04_instr", 32'(if_instr), 32'h0);
    redirect = 1'b0; stall = 1'b1;
    tick();
    tick();
    chk("stl_state", 32'(fetch_state), 32'd2);
    chk("stl_pc",    32'(pc), 32'h04);
    chk("stl_count", 32'(fetch_count), 32'd3);
    chk("stl_instr", 32'(if_instr), 32'h0);
    stall = 1'b0;
    tick();
    chk("unstl_instr", 32'(if_instr), 32'h047000);
    chk("unstl_valid", 32'(if_valid), 32'h1);
    chk("unstl_count", 32'(fetch_count), 32'd4);

    // redirect beats stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h20;
    tick();
    chk("rdst_pc",    32'(pc), 32'h20);
    chk("rdst_valid", 32'(if_valid), 32'h0);
    chk("rdst_state", 32'(fetch_state), 32'd1);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("rdst_tag",   32'(if_instr[23:16]), 32'h20);
    chk("rdst_v1",    32'(if_valid), 32'h1);
    chk("rdst_count", 32'(fetch_count), 32'd5);

    // odd target, then wrap at FE
    redirect = 1'b1; redirect_pc = 8'hFD;
    tick();
    chk("odd_pc", 32'(pc), 32'hFD);
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_instr", 32'(if_instr), 32'hFEABCD);
    chk("wrap_pc",    32'(pc), 32'h00);
    chk("wrap_count", 32'(fetch_count), 32'd6);
    for (int i = 0; i < 250; i++) tick();
    chk("cnt_wrap",    32'(fetch_count), 32'd0);
    chk("cnt_wrap_pc", 32'(pc), 32'hF4);

    // halt at 40
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_state", 32'(fetch_state), 32'd3);
    for (int i = 0; i < 5; i++) begin
      stall = ~stall;
      tick();
      chk("halt_pc",    32'(pc), 32'h40);
      chk("halt_valid", 32'(if_valid), 32'h0);
      chk("halt_hold",  32'(fetch_state), 32'd3);
    end
    stall = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_state", 32'(fetch_state), 32'd1);
    chk("resume_pc",    32'(pc), 32'h40);
    tick();
    chk("resume_tag",   32'(if_instr[23:16]), 32'h40);
    chk("resume_valid", 32'(if_valid), 32'h1);
    chk("resume_count", 32'(fetch_count), 32'd1);

    // async reset mid-STALL
    stall = 1'b1;
    tick();
    chk("pre_rst_state", 32'(fetch_state), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc",    32'(pc), 32'h00);
    chk("arst_instr", 32'(if_instr), 32'h0);
    chk("arst_valid", 32'(if_valid), 32'h0);
    chk("arst_count", 32'(fetch_count), 32'd0);
    chk("arst_state", 32'(fetch_state), 32'd0);
    tick();
    reset = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 8'h55;
    tick();
    chk("boot2_pc",    32'(pc), 32'h00);
    chk("boot2_state", 32'(fetch_state), 32'd1);
    redirect = 1'b0;
    tick();
    chk("post_instr", 32'(if_instr), 32'h000000);
    chk("post_valid", 32'(if_valid), 32'h1);
    chk("post_pc",    32'(pc), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
